// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, load/store and memory-macro signals around mem_port_arbiter.
// The slave modport is the arbiter's view; the master modport is the pipeline/memory side.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 10
);
    logic              if_req;
    logic [31:0]       if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [31:0]       if_rdata;
    logic              flush;

    logic              dm_req;
    logic              dm_we;
    logic [1:0]        dm_size;
    logic [31:0]       dm_addr;
    logic [31:0]       dm_wdata;
    logic              dm_gnt;
    logic              dm_rvalid;
    logic [31:0]       dm_rdata;
    logic              dm_err;

    logic              mem_en;
    logic              mem_we;
    logic [3:0]        mem_be;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    logic              busy;

    modport slave (
        input  if_req, if_addr, flush,
        input  dm_req, dm_we, dm_size, dm_addr, dm_wdata,
        input  mem_rdata,
        output if_gnt, if_rvalid, if_rdata,
        output dm_gnt, dm_rvalid, dm_rdata, dm_err,
        output mem_en, mem_we, mem_be, mem_addr, mem_wdata,
        output busy
    );

    modport master (
        output if_req, if_addr, flush,
        output dm_req, dm_we, dm_size, dm_addr, dm_wdata,
        output mem_rdata,
        input  if_gnt, if_rvalid, if_rdata,
        input  dm_gnt, dm_rvalid, dm_rdata, dm_err,
        input  mem_en, mem_we, mem_be, mem_addr, mem_wdata,
        input  busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency single-port memory between instruction fetch and load/store,
// with store lane formatting, load sign-extension, starvation guard and fetch flush.
module mem_port_arbiter #(
    parameter int ADDR_W     = 10,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    mem_port_arbiter_if.slave bus
);
    localparam int WAIT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam int STV_W  = $clog2(STARVE_MAX + 1);
    localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(MEM_LAT - 1);
    localparam logic [STV_W-1:0]  STV_MAX   = STV_W'(STARVE_MAX);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_RESP} state_t;

    state_t            state_q, state_d;
    logic              owner_q, owner_d;      // 1 = data port, 0 = fetch
    logic              we_q, we_d;
    logic [1:0]        size_q, size_d;
    logic [1:0]        off_q, off_d;
    logic              err_q, err_d;
    logic              drop_q, drop_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [STV_W-1:0]  starve_cnt_q, starve_cnt_d;

    logic              if_gnt_q, if_gnt_d;
    logic              if_rvalid_q, if_rvalid_d;
    logic [31:0]       if_rdata_q, if_rdata_d;
    logic              dm_gnt_q, dm_gnt_d;
    logic              dm_rvalid_q, dm_rvalid_d;
    logic [31:0]       dm_rdata_q, dm_rdata_d;
    logic              dm_err_q, dm_err_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [3:0]        mem_be_q, mem_be_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic              busy_q, busy_d;

    logic        dm_bad;
    logic [3:0]  st_be;
    logic [31:0] st_wdata;
    logic [31:0] ld_value;
    logic [7:0]  rd_lane [4];
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic        grant_data;
    logic        grant_fetch;
    logic        unused_addr_bits;

    assign unused_addr_bits = ^{bus.if_addr[31:ADDR_W+2], bus.if_addr[1:0],
                                bus.dm_addr[31:ADDR_W+2]};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign rd_lane[gi] = bus.mem_rdata[8*gi +: 8];
        end
    endgenerate

    // Alignment / legality of the data request as presented in IDLE
    always_comb begin
        dm_bad = 1'b0;
        case (bus.dm_size)
            2'b00:   dm_bad = 1'b0;
            2'b01:   dm_bad = bus.dm_addr[0];
            2'b10:   dm_bad = (bus.dm_addr[1:0] != 2'b00);
            default: dm_bad = 1'b1;
        endcase
    end

    always_comb begin
        st_be    = 4'hF;
        st_wdata = bus.dm_wdata;
        case (bus.dm_size)
            2'b00: begin
                st_be    = 4'b0001 << bus.dm_addr[1:0];
                st_wdata = {4{bus.dm_wdata[7:0]}};
            end
            2'b01: begin
                st_be    = bus.dm_addr[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{bus.dm_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    // Lane select uses the offset/size latched at grant time
    always_comb begin
        ld_byte  = rd_lane[off_q];
        ld_half  = off_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
        ld_value = bus.mem_rdata;
        case (size_q)
            2'b00:   ld_value = {{24{ld_byte[7]}}, ld_byte};
            2'b01:   ld_value = {{16{ld_half[15]}}, ld_half};
            default: ld_value = bus.mem_rdata;
        endcase
    end

    assign grant_data  = (state_q == S_IDLE) && bus.dm_req &&
                         !(bus.if_req && (starve_cnt_q == STV_MAX));
    assign grant_fetch = (state_q == S_IDLE) && bus.if_req && !grant_data;

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        we_d         = we_q;
        size_d       = size_q;
        off_d        = off_q;
        err_d        = err_q;
        drop_d       = drop_q;
        wait_d       = wait_q;
        starve_cnt_d = starve_cnt_q;
        if_gnt_d     = 1'b0;
        if_rvalid_d  = 1'b0;
        if_rdata_d   = '0;
        dm_gnt_d     = 1'b0;
        dm_rvalid_d  = 1'b0;
        dm_rdata_d   = '0;
        dm_err_d     = 1'b0;
        mem_en_d     = 1'b0;
        mem_we_d     = 1'b0;
        mem_be_d     = '0;
        mem_addr_d   = '0;
        mem_wdata_d  = '0;
        busy_d       = 1'b0;

        case (state_q)
            S_IDLE: begin
                drop_d = 1'b0;
                if (grant_data) begin
                    state_d  = S_ACCESS;
                    owner_d  = 1'b1;
                    we_d     = bus.dm_we;
                    size_d   = bus.dm_size;
                    off_d    = bus.dm_addr[1:0];
                    err_d    = dm_bad;
                    dm_gnt_d = 1'b1;
                    busy_d   = 1'b1;
                    if (!dm_bad) begin
                        mem_en_d    = 1'b1;
                        mem_we_d    = bus.dm_we;
                        mem_be_d    = bus.dm_we ? st_be : 4'hF;
                        mem_addr_d  = bus.dm_addr[ADDR_W+1:2];
                        mem_wdata_d = bus.dm_we ? st_wdata : '0;
                    end
                    if (!bus.if_req) begin
                        starve_cnt_d = '0;
                    end else if (starve_cnt_q != STV_MAX) begin
                        starve_cnt_d = starve_cnt_q + 1'b1;
                    end
                end else if (grant_fetch) begin
                    state_d      = S_ACCESS;
                    owner_d      = 1'b0;
                    we_d         = 1'b0;
                    size_d       = 2'b10;
                    off_d        = 2'b00;
                    err_d        = 1'b0;
                    if_gnt_d     = 1'b1;
                    busy_d       = 1'b1;
                    mem_en_d     = 1'b1;
                    mem_be_d     = 4'hF;
                    mem_addr_d   = bus.if_addr[ADDR_W+1:2];
                    starve_cnt_d = '0;
                end else begin
                    starve_cnt_d = '0;
                end
            end

            S_ACCESS: begin
                busy_d = 1'b1;
                if (!owner_q && bus.flush) drop_d = 1'b1;
                if (err_q || we_q) begin
                    state_d     = S_RESP;
                    dm_rvalid_d = 1'b1;
                    dm_err_d    = err_q;
                end else begin
                    state_d = S_WAIT;
                    wait_d  = WAIT_INIT;
                end
            end

            S_WAIT: begin
                busy_d = 1'b1;
                if (!owner_q && bus.flush) drop_d = 1'b1;
                if (wait_q == '0) begin
                    state_d = S_RESP;
                    if (owner_q) begin
                        dm_rvalid_d = 1'b1;
                        dm_rdata_d  = ld_value;
                    end else begin
                        if_rvalid_d = !drop_d;
                        if_rdata_d  = bus.mem_rdata;
                    end
                end else begin
                    wait_d = wait_q - 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
                drop_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            owner_q      <= 1'b0;
            we_q         <= 1'b0;
            size_q       <= 2'b00;
            off_q        <= 2'b00;
            err_q        <= 1'b0;
            drop_q       <= 1'b0;
            wait_q       <= '0;
            starve_cnt_q <= '0;
            if_gnt_q     <= 1'b0;
            if_rvalid_q  <= 1'b0;
            if_rdata_q   <= '0;
            dm_gnt_q     <= 1'b0;
            dm_rvalid_q  <= 1'b0;
            dm_rdata_q   <= '0;
            dm_err_q     <= 1'b0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_be_q     <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            we_q         <= we_d;
            size_q       <= size_d;
            off_q        <= off_d;
            err_q        <= err_d;
            drop_q       <= drop_d;
            wait_q       <= wait_d;
            starve_cnt_q <= starve_cnt_d;
            if_gnt_q     <= if_gnt_d;
            if_rvalid_q  <= if_rvalid_d;
            if_rdata_q   <= if_rdata_d;
            dm_gnt_q     <= dm_gnt_d;
            dm_rvalid_q  <= dm_rvalid_d;
            dm_rdata_q   <= dm_rdata_d;
            dm_err_q     <= dm_err_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_be_q     <= mem_be_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            busy_q       <= busy_d;
        end
    end

    // A flush in the response cycle itself still cancels the fetch data
    assign bus.if_rvalid = if_rvalid_q & ~bus.flush;
    assign bus.if_gnt    = if_gnt_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.dm_gnt    = dm_gnt_q;
    assign bus.dm_rvalid = dm_rvalid_q;
    assign bus.dm_rdata  = dm_rdata_q;
    assign bus.dm_err    = dm_err_q;
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_be    = mem_be_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a one-cycle-latency memory model, a response
// scoreboard and a grant-order queue, checked with immediate assertions.
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b1;

    mem_port_arbiter_if #(.ADDR_W(10)) bus ();

    mem_port_arbiter #(.ADDR_W(10), .MEM_LAT(1), .STARVE_MAX(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Memory model with a preload port so the bench never writes the array directly
    logic [31:0] mem [1024];
    logic [31:0] rd_q = '0;
    logic        pre_we = 1'b0;
    logic [9:0]  pre_addr = '0;
    logic [31:0] pre_data = '0;

    always @(posedge clk) begin
        if (pre_we) begin
            mem[pre_addr] <= pre_data;
        end else if (bus.mem_en && bus.mem_we) begin
            for (int i = 0; i < 4; i++)
                if (bus.mem_be[i]) mem[bus.mem_addr][8*i +: 8] <= bus.mem_wdata[8*i +: 8];
        end
        if (bus.mem_en) rd_q <= mem[bus.mem_addr];
    end
    assign bus.mem_rdata = rd_q;

    typedef struct {
        logic        is_fetch;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    logic [1:0]  order_q[$];
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [9:0] a, input logic [31:0] d);
        @(negedge clk);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    task automatic issue(input string tag, input bit fetch, input bit we, input logic [1:0] size,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rdata, input bit exp_err,
                         input logic [3:0] exp_be, input logic [31:0] exp_wdata);
        exp_t e;
        int   n;
        bit   got;
        bit   saw_en;
        logic [31:0] obs_rd;
        e.is_fetch = fetch; e.rdata = exp_rdata; e.err = exp_err;
        sb.push_back(e);
        @(negedge clk);
        if (fetch) begin
            bus.if_req = 1'b1; bus.if_addr = addr;
        end else begin
            bus.dm_req = 1'b1; bus.dm_we = we; bus.dm_size = size;
            bus.dm_addr = addr; bus.dm_wdata = wdata;
        end
        n = 0; got = 1'b0;
        while (!got && n < 8) begin
            @(negedge clk); n++;
            got = fetch ? bus.if_gnt : bus.dm_gnt;
        end
        check({tag, " gnt_lat"}, n, 1);
        check({tag, " mem_en"}, {31'b0, bus.mem_en}, {31'b0, !exp_err});
        if (!exp_err) begin
            check({tag, " mem_we"}, {31'b0, bus.mem_we}, {31'b0, we});
            check({tag, " mem_be"}, {28'b0, bus.mem_be}, {28'b0, exp_be});
            check({tag, " mem_addr"}, {22'b0, bus.mem_addr}, {22'b0, addr[11:2]});
            if (we) check({tag, " mem_wdata"}, bus.mem_wdata, exp_wdata);
        end
        bus.if_req = 1'b0; bus.dm_req = 1'b0;
        n = 0; got = 1'b0; saw_en = 1'b0;
        while (!got && n < 8) begin
            @(negedge clk); n++;
            if (bus.mem_en) saw_en = 1'b1;
            got = fetch ? bus.if_rvalid : bus.dm_rvalid;
        end
        check({tag, " rsp_lat"}, n, (we || exp_err) ? 1 : 2);
        if (exp_err) check({tag, " no_mem_en"}, {31'b0, saw_en}, 32'd0);
        e = sb.pop_front();
        obs_rd = e.is_fetch ? bus.if_rdata : bus.dm_rdata;
        check({tag, " rdata"}, obs_rd, e.rdata);
        if (!e.is_fetch) check({tag, " err"}, {31'b0, bus.dm_err}, {31'b0, e.err});
        $display("txn %s addr=%h rdata=%h err=%b lat=%0d", tag, addr, obs_rd, bus.dm_err, n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n;
        bit   got;
        bit   bad;
        logic [1:0] exp_g;

        bus.if_req = 0; bus.if_addr = 0; bus.flush = 0;
        bus.dm_req = 0; bus.dm_we = 0; bus.dm_size = 0; bus.dm_addr = 0; bus.dm_wdata = 0;

        #2 rst_n = 1'b0;
        #1;
        check("reset busy", {31'b0, bus.busy}, 32'd0);
        check("reset outs", {bus.if_gnt, bus.if_rvalid, bus.dm_gnt, bus.dm_rvalid, bus.dm_err,
                             bus.mem_en, bus.mem_we, bus.mem_be}, 32'd0);
        preload(10'd4,    32'h00A0_0093);
        preload(10'h40,   32'h8000_0000);
        preload(10'd8,    32'h1111_1111);
        preload(10'h10,   32'hDEAD_BEEF);
        preload(10'd1,    32'h5555_5555);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);

        // Reset in the middle of a fetch's WAIT cycle
        bus.if_req = 1'b1; bus.if_addr = 32'h40;
        @(negedge clk);
        check("rst_fetch gnt", {31'b0, bus.if_gnt}, 32'd1);
        bus.if_req = 1'b0;
        @(negedge clk);
        check("rst_fetch busy_wait", {31'b0, bus.busy}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("rst_async busy", {31'b0, bus.busy}, 32'd0);
        check("rst_async outs", {bus.if_gnt, bus.if_rvalid, bus.dm_gnt, bus.dm_rvalid,
                                 bus.dm_err, bus.mem_en, bus.mem_we, bus.mem_be}, 32'd0);
        check("rst_async rdata", bus.if_rdata | bus.dm_rdata | bus.mem_wdata, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        bad = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (bus.if_rvalid || bus.busy) bad = 1'b1;
        end
        check("rst_no_rvalid", {31'b0, bad}, 32'd0);
        $display("txn reset_mid_wait if_addr=00000040 rvalid_after=%b", bad);

        // Directed single transactions: tag fetch we size addr wdata rdata err be wdata
        issue("fetch_10", 1, 0, 2'b10, 32'h10,  32'h0,        32'h00A0_0093, 0, 4'hF,    32'h0);
        issue("lb_103",   0, 0, 2'b00, 32'h103, 32'h0,        32'hFFFF_FF80, 0, 4'hF,    32'h0);
        issue("sh_22",    0, 1, 2'b01, 32'h22,  32'h1234_ABCD, 32'h0,        0, 4'b1100, 32'hABCD_ABCD);
        issue("sw_22_err",0, 1, 2'b10, 32'h22,  32'hFFFF_FFFF, 32'h0,        1, 4'hF,    32'h0);
        issue("lw_20",    0, 0, 2'b10, 32'h20,  32'h0,        32'hABCD_1111, 0, 4'hF,    32'h0);
        issue("lw_06_err",0, 0, 2'b10, 32'h6,   32'h0,        32'h0,         1, 4'hF,    32'h0);
        issue("lh_22",    0, 0, 2'b01, 32'h22,  32'h0,        32'hFFFF_ABCD, 0, 4'hF,    32'h0);
        issue("lb_21",    0, 0, 2'b00, 32'h21,  32'h0,        32'h0000_0011, 0, 4'hF,    32'h0);
        issue("sb_101",   0, 1, 2'b00, 32'h101, 32'h0000_007F, 32'h0,        0, 4'b0010, 32'h7F7F_7F7F);
        issue("lw_100",   0, 0, 2'b10, 32'h100, 32'h0,        32'h8000_7F00, 0, 4'hF,    32'h0);
        issue("sz11_err", 0, 0, 2'b11, 32'h100, 32'h0,        32'h0,         1, 4'hF,    32'h0);
        issue("lh_102",   0, 0, 2'b01, 32'h102, 32'h0,        32'hFFFF_8000, 0, 4'hF,    32'h0);
        issue("fetch_40", 1, 0, 2'b10, 32'h40,  32'h0,        32'hDEAD_BEEF, 0, 4'hF,    32'h0);

        // Flush pulsed while the fetch is in WAIT
        @(negedge clk);
        bus.if_req = 1'b1; bus.if_addr = 32'h10;
        @(negedge clk);
        check("flush_wait gnt", {31'b0, bus.if_gnt}, 32'd1);
        bus.if_req = 1'b0;
        @(negedge clk);
        bus.flush = 1'b1;
        check("flush_wait busy_w", {31'b0, bus.busy}, 32'd1);
        @(negedge clk);
        bus.flush = 1'b0;
        #1;
        check("flush_wait rvalid", {31'b0, bus.if_rvalid}, 32'd0);
        check("flush_wait busy_r", {31'b0, bus.busy}, 32'd1);
        @(negedge clk);
        check("flush_wait busy_i", {31'b0, bus.busy}, 32'd0);
        check("flush_wait late", {31'b0, bus.if_rvalid}, 32'd0);
        $display("txn fetch_flush_wait addr=00000010 rvalid=%b", bus.if_rvalid);

        // Flush during the response cycle gates if_rvalid combinationally
        @(negedge clk);
        bus.if_req = 1'b1; bus.if_addr = 32'h10;
        @(negedge clk);
        bus.if_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        bus.flush = 1'b1;
        #1;
        check("flush_resp gated", {31'b0, bus.if_rvalid}, 32'd0);
        bus.flush = 1'b0;
        #1;
        check("flush_resp open", {31'b0, bus.if_rvalid}, 32'd1);
        $display("txn fetch_flush_resp addr=00000010 rdata=%h", bus.if_rdata);
        @(negedge clk);

        // Both requesters held: four data grants, then a forced fetch grant
        order_q = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10};
        @(negedge clk);
        bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_size = 2'b10; bus.dm_addr = 32'h100;
        bus.if_req = 1'b1; bus.if_addr = 32'h10;
        for (int k = 0; k < 10; k++) begin
            n = 0; got = 1'b0;
            while (!got && n < 12) begin
                @(negedge clk); n++;
                got = bus.if_gnt | bus.dm_gnt;
            end
            exp_g = order_q.pop_front();
            check($sformatf("starve order%0d", k), {30'b0, bus.if_gnt, bus.dm_gnt}, {30'b0, exp_g});
            $display("txn grant %0d owner=%s", k, bus.dm_gnt ? "data" : "fetch");
        end
        bus.if_req = 1'b0; bus.dm_req = 1'b0;
        n = 0;
        while (bus.busy && n < 12) begin
            @(negedge clk); n++;
        end
        check("starve drain busy", {31'b0, bus.busy}, 32'd0);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port, fixed-latency instruction/data memory between two requesters: the fetch stage (word reads) and the load/store stage (LB/LH/LW, SB/SH/SW).
- Sequences each access with a registered FSM, formats store byte-lanes and load sign-extension, and cancels fetch responses on a taken-branch flush.
- Sits between the pipeline stages and the memory macro.

Parameters:
ADDR_W, 10, memory word-address width (1024 words)
MEM_LAT, 1, cycles from mem_en to valid mem_rdata (>=1)
STARVE_MAX, 4, consecutive data grants allowed while fetch waits before fetch is forced

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
if_req  in  1  fetch request; held until if_gnt
if_addr  in  32  fetch byte address; bits [1:0] ignored
if_gnt  out  1  fetch accepted (1-cycle pulse)
if_rvalid  out  1  fetch data valid (1-cycle pulse)
if_rdata  out  32  fetched instruction word
flush  in  1  taken branch; cancels an in-flight fetch response
dm_req  in  1  data request; held until dm_gnt
dm_we  in  1  1 = store, 0 = load
dm_size  in  2  00 byte, 01 half, 10 word; 11 is illegal
dm_addr  in  32  data byte address
dm_wdata  in  32  store data, right-aligned
dm_gnt  out  1  data accepted (1-cycle pulse)
dm_rvalid  out  1  load data valid or store done (1-cycle pulse)
dm_rdata  out  32  sign-extended load result
dm_err  out  1  misaligned or illegal access; valid with dm_rvalid
mem_en  out  1  memory access strobe
mem_we  out  1  memory write enable
mem_be  out  4  byte-lane enables
mem_addr  out  ADDR_W  word address = addr[ADDR_W+1:2]
mem_wdata  out  32  lane-replicated store data
mem_rdata  in  32  memory read data
busy  out  1  FSM not IDLE

Behaviour:
- Reset (async, rst_n=0):
  - FSM goes to IDLE. All outputs are 0. starve_cnt=0, drop flag=0.
  - Any in-flight transaction is discarded; no rvalid follows.
- States: IDLE, ACCESS, WAIT, RESP. All outputs are registered, except if_rvalid, which is gated by ~flush.
- IDLE:
  - Requests are sampled at the clock edge.
  - Winner selection: data has priority over fetch. If if_req=1 and starve_cnt==STARVE_MAX, fetch wins instead.
  - On any grant, the winner's address, data, size and owner are latched and the FSM goes to ACCESS.
- ACCESS (1 cycle):
  - Owner's gnt=1 and mem_en=1; mem_we, mem_be, mem_addr and mem_wdata are valid.
  - Load or fetch goes to WAIT. Store goes to RESP.
  - Error access: mem_en=0, gnt=1, then RESP with err=1.
- WAIT: lasts MEM_LAT cycles. mem_rdata is captured at the end of the last WAIT cycle, then the FSM goes to RESP.
- RESP (1 cycle):
  - Owner's rvalid=1 with rdata; the FSM returns to IDLE.
  - A new request is first sampled at the end of the following IDLE cycle.
- Latency with MEM_LAT=1, request first seen at edge E0:
  - gnt in cycle E0+1.
  - Load/fetch rvalid in cycle E0+3.
  - Store ack in cycle E0+2.
- Starvation counter:
  - Increments (saturating at STARVE_MAX) on each data grant while if_req=1.
  - Clears on a fetch grant, or in any IDLE cycle with if_req=0.
- Store formatting:
  - Byte: mem_be = 1 << addr[1:0]; mem_wdata = {4{wdata[7:0]}}.
  - Half: mem_be = 0011 or 1100 by addr[1]; mem_wdata = {2{wdata[15:0]}}.
  - Word: mem_be = 1111.
- Loads: the lane is selected by addr[1:0] and sign-extended to 32 bits. For loads and fetches, mem_be = 1111 and mem_we = 0.
- Errors: half access with addr[0]=1, word access with addr[1:0]!=0, or dm_size=11. Then dm_err=1, dm_rdata=0, and memory is untouched.
- Flush:
  - flush=1 in any cycle while the fetch owner is in ACCESS or WAIT sets drop. The transaction completes but if_rvalid is suppressed.
  - flush=1 during fetch RESP also gates if_rvalid.
  - flush never affects data transactions or the grant decision.
  - drop clears on return to IDLE.
- Simultaneous if_req and dm_req: data wins (subject to starvation). if_req stays pending and is served next.
- Requests in a non-IDLE state are ignored (no gnt) until IDLE.

Test Plan:
- Reset mid-WAIT of a fetch to 0x40 (pull rst_n low asynchronously) -> all outputs 0 immediately; no if_rvalid after release.
- Fetch 0x0000_0010 with mem word 4 = 0x00A0_0093, MEM_LAT=1 -> if_gnt at E0+1 with mem_addr=4; if_rvalid at E0+3 with if_rdata=0x00A0_0093.
- LB addr 0x0000_0103, mem word 0x40 = 0x8000_0000 -> mem_addr=0x40; dm_rdata=0xFFFF_FF80.
- SH addr 0x0000_0022, wdata 0x1234_ABCD -> mem_be=1100, mem_wdata=0xABCD_ABCD, mem_addr=8; dm_rvalid at E0+2.
- LW addr 0x0000_0006 -> dm_err=1, dm_rdata=0, mem_en never asserted.
- Both requests held continuously, STARVE_MAX=4 -> grant order D,D,D,D,I,D,...
- Fetch in WAIT with flush pulsed -> no if_rvalid; busy drops on schedule.
